// File: rtl/i2c_target_if.sv
// Received-byte stream and status of the I2C write target.
// The target drives the stream side; the consumer owns rx_ready.
`timescale 1ns/1ps
interface i2c_target_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       rx_ready;
    logic       busy;
    logic       stop_pulse;
    logic       overrun;

    modport master (
        output rx_valid, rx_data, rx_first, busy, stop_pulse, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_valid, rx_data, rx_first, busy, stop_pulse, overrun,
        output rx_ready
    );
endinterface

// File: rtl/i2c_target.sv
// Write-only I2C target: synchronizes and filters SCL/SDA, decodes the
// address and streams received bytes out with a valid/ready handshake.
//
// state    | meaning
// IDLE     | bus free or not addressed; waiting for START
// ADDR     | shifting in {addr, rw}
// ADDR_ACK | acknowledging a matching write address
// DATA     | shifting in a data byte
// DATA_ACK | ACK (byte taken) or NACK (previous byte still pending)
// IGNORE   | addressed elsewhere or read request; SDA left alone
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] I2C_ADDR   = 7'b1100000,
    parameter int         FILTER_LEN = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i2c_scl,
    inout  wire          i2c_sda,
    i2c_target_if.master rx_if
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] FLT_LOAD = CW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    line_f;
    logic [CW-1:0] flt_cnt [2];

    logic scl_f, sda_f, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] byte_nxt;
    logic       sda_pull;
    logic       ack_ok;
    logic       ack_slot;
    logic       first_flag;
    logic       busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       stop_pulse;
    logic       overrun;

    // A level change is taken only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            line_f     <= 2'b11;
            flt_cnt[0] <= FLT_LOAD;
            flt_cnt[1] <= FLT_LOAD;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            sync1 <= {i2c_sda, i2c_scl};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == line_f[i]) begin
                    flt_cnt[i] <= FLT_LOAD;
                end else if (flt_cnt[i] == '0) begin
                    line_f[i]  <= sync2[i];
                    flt_cnt[i] <= FLT_LOAD;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] - 1'b1;
                end
            end
            scl_q <= line_f[0];
            sda_q <= line_f[1];
        end
    end

    assign scl_f     = line_f[0];
    assign sda_f     = line_f[1];
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_nxt  = {shift, sda_f};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            sda_pull   <= 1'b0;
            ack_ok     <= 1'b0;
            ack_slot   <= 1'b0;
            first_flag <= 1'b0;
            busy       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_first   <= 1'b0;
            stop_pulse <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            stop_pulse <= 1'b0;
            overrun    <= 1'b0;
            // Accept first so a byte completing in the same cycle still lands.
            if (rx_valid && rx_if.rx_ready)
                rx_valid <= 1'b0;

            if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                shift    <= '0;
                sda_pull <= 1'b0;
                ack_slot <= 1'b0;
            end else if (stop_det) begin
                state      <= IDLE;
                sda_pull   <= 1'b0;
                ack_slot   <= 1'b0;
                busy       <= 1'b0;
                stop_pulse <= busy;
            end else begin
                unique case (state)
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shift   <= byte_nxt[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_slot <= 1'b0;
                                if (state == ADDR) begin
                                    if (byte_nxt == {I2C_ADDR, 1'b0}) begin
                                        state      <= ADDR_ACK;
                                        busy       <= 1'b1;
                                        first_flag <= 1'b1;
                                        ack_ok     <= 1'b1;
                                    end else begin
                                        state <= IGNORE;
                                        busy  <= 1'b0;
                                    end
                                end else begin
                                    state <= DATA_ACK;
                                    if (rx_valid && !rx_if.rx_ready) begin
                                        overrun <= 1'b1;
                                        ack_ok  <= 1'b0;
                                    end else begin
                                        rx_data    <= byte_nxt;
                                        rx_first   <= first_flag;
                                        rx_valid   <= 1'b1;
                                        first_flag <= 1'b0;
                                        ack_ok     <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // First falling edge opens the ACK slot, the second closes it.
                        if (scl_fall) begin
                            if (!ack_slot) begin
                                sda_pull <= ack_ok;
                                ack_slot <= 1'b1;
                            end else begin
                                sda_pull <= 1'b0;
                                ack_slot <= 1'b0;
                                bit_cnt  <= '0;
                                state    <= DATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sda = sda_pull ? 1'b0 : 1'bz;

    assign rx_if.rx_valid   = rx_valid;
    assign rx_if.rx_data    = rx_data;
    assign rx_if.rx_first   = rx_first;
    assign rx_if.busy       = busy;
    assign rx_if.stop_pulse = stop_pulse;
    assign rx_if.overrun    = overrun;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an open-drain bus master model writes
// byte sequences and the results are compared against hand-computed values.
`timescale 1ns/1ps
module tb_i2c_target;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic scl     = 1'b1;
    logic sda_low = 1'b0;
    wire  sda_w;

    assign sda_w = sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_target_if rx_if ();

    i2c_target dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i2c_scl (scl),
        .i2c_sda (sda_w),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    int q = 10;
    int n_checks = 0;
    int n_fail   = 0;

    int         rx_cnt   = 0;
    int         stop_cnt = 0;
    int         ovr_cnt  = 0;
    int         pull_cnt = 0;
    logic [8:0] rx_log [64];

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                if (rx_cnt < 64) rx_log[rx_cnt] = {rx_if.rx_first, rx_if.rx_data};
                rx_cnt++;
            end
            if (rx_if.stop_pulse) stop_cnt++;
            if (rx_if.overrun) ovr_cnt++;
            if (sda_w === 1'b0 && !sda_low) pull_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_start();
        sda_low = 1'b0; wait_clk(q);
        scl = 1'b1;     wait_clk(q);
        sda_low = 1'b1; wait_clk(q);
        scl = 1'b0;     wait_clk(q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; wait_clk(q);
        scl = 1'b1;     wait_clk(q);
        sda_low = 1'b0; wait_clk(q);
    endtask

    // glitch=1 injects a 1-clk SCL pulse while low and a 1-clk SDA flip while SCL is high on bit 3
    task automatic send_bits(input logic [7:0] b, input bit glitch);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i];
            if (glitch && i == 3) begin
                wait_clk(q / 2);
                scl = 1'b1; wait_clk(1);
                scl = 1'b0; wait_clk(q - q / 2 - 1);
            end else begin
                wait_clk(q);
            end
            scl = 1'b1;
            if (glitch && i == 3) begin
                wait_clk(q);
                sda_low = ~sda_low; wait_clk(1);
                sda_low = ~sda_low; wait_clk(q - 1);
            end else begin
                wait_clk(2 * q);
            end
            scl = 1'b0;
            wait_clk(q);
        end
    endtask

    task automatic ack_bit(output logic ack);
        sda_low = 1'b0; wait_clk(q);
        scl = 1'b1;     wait_clk(q);
        ack = (sda_w === 1'b0);
        wait_clk(q);
        scl = 1'b0;     wait_clk(q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack, input bit glitch);
        send_bits(b, glitch);
        ack_bit(ack);
    endtask

    initial begin
        logic a, a2;
        int   rb, sb, ob, pb;

        rx_if.rx_ready = 1'b1;
        reset_n = 1'b0;
        wait_clk(3);
        check_val("rst_rx_valid", rx_if.rx_valid, 0);
        check_val("rst_busy", rx_if.busy, 0);
        check_val("rst_rx_data", rx_if.rx_data, 0);
        check_val("rst_rx_first", rx_if.rx_first, 0);
        check_val("rst_stop_pulse", rx_if.stop_pulse, 0);
        check_val("rst_overrun", rx_if.overrun, 0);
        check_val("rst_sda", sda_w, 1);
        reset_n = 1'b1;
        wait_clk(5);

        // four-byte write at about 400 kHz
        q = 62;
        rb = rx_cnt; sb = stop_cnt; ob = ovr_cnt;
        bus_start();
        write_byte(8'hC0, a, 0); check_val("w4_ack_addr", a, 1);
        write_byte(8'h42, a, 0); check_val("w4_ack_42", a, 1);
        write_byte(8'h0A, a, 0); check_val("w4_ack_0a", a, 1);
        write_byte(8'hBC, a, 0); check_val("w4_ack_bc", a, 1);
        bus_stop();
        wait_clk(4);
        check_val("w4_rx_count", rx_cnt - rb, 3);
        check_val("w4_byte0", rx_log[rb], 9'h142);
        check_val("w4_byte1", rx_log[rb + 1], 9'h00A);
        check_val("w4_byte2", rx_log[rb + 2], 9'h0BC);
        check_val("w4_stop_pulses", stop_cnt - sb, 1);
        check_val("w4_overruns", ovr_cnt - ob, 0);
        check_val("w4_busy_after_stop", rx_if.busy, 0);

        // address mismatch
        q = 10;
        rb = rx_cnt; sb = stop_cnt; pb = pull_cnt;
        bus_start();
        write_byte(8'hC2, a, 0); check_val("mis_ack_addr", a, 0);
        write_byte(8'h11, a, 0);
        write_byte(8'h22, a2, 0); check_val("mis_ack_data", {a, a2}, 0);
        bus_stop();
        wait_clk(4);
        check_val("mis_sda_pulls", pull_cnt - pb, 0);
        check_val("mis_rx_count", rx_cnt - rb, 0);
        check_val("mis_stop_pulses", stop_cnt - sb, 0);

        // read request is not supported
        sb = stop_cnt; pb = pull_cnt;
        bus_start();
        write_byte(8'hC1, a, 0); check_val("rd_ack_addr", a, 0);
        check_val("rd_busy", rx_if.busy, 0);
        bus_stop();
        wait_clk(4);
        check_val("rd_stop_pulses", stop_cnt - sb, 0);
        check_val("rd_sda_pulls", pull_cnt - pb, 0);

        // consumer stalled: second byte overruns
        rx_if.rx_ready = 1'b0;
        rb = rx_cnt; sb = stop_cnt; ob = ovr_cnt;
        bus_start();
        write_byte(8'hC0, a, 0); check_val("ovr_ack_addr", a, 1);
        write_byte(8'h11, a, 0); check_val("ovr_ack_11", a, 1);
        write_byte(8'h22, a, 0); check_val("ovr_ack_22", a, 0);
        check_val("ovr_pulses", ovr_cnt - ob, 1);
        check_val("ovr_rx_valid", rx_if.rx_valid, 1);
        check_val("ovr_rx_data", rx_if.rx_data, 8'h11);
        check_val("ovr_rx_first", rx_if.rx_first, 1);
        bus_stop();
        wait_clk(4);
        check_val("ovr_stop_pulses", stop_cnt - sb, 1);
        check_val("ovr_valid_after_stop", rx_if.rx_valid, 1);
        check_val("ovr_data_after_stop", rx_if.rx_data, 8'h11);
        rx_if.rx_ready = 1'b1;
        wait_clk(2);
        check_val("ovr_rx_count", rx_cnt - rb, 1);
        check_val("ovr_logged", rx_log[rb], 9'h111);
        check_val("ovr_valid_cleared", rx_if.rx_valid, 0);

        // repeated START to the same address
        rb = rx_cnt; sb = stop_cnt;
        bus_start();
        write_byte(8'hC0, a, 0);
        write_byte(8'h55, a, 0); check_val("rs_ack_55", a, 1);
        check_val("rs_busy_before", rx_if.busy, 1);
        bus_start();
        check_val("rs_busy_after_start", rx_if.busy, 1);
        write_byte(8'hC0, a, 0); check_val("rs_ack_addr2", a, 1);
        check_val("rs_busy_after_addr", rx_if.busy, 1);
        write_byte(8'h66, a, 0); check_val("rs_ack_66", a, 1);
        bus_stop();
        wait_clk(4);
        check_val("rs_rx_count", rx_cnt - rb, 2);
        check_val("rs_byte0", rx_log[rb], 9'h155);
        check_val("rs_byte1", rx_log[rb + 1], 9'h166);
        check_val("rs_stop_pulses", stop_cnt - sb, 1);

        // single-clock glitches on SCL and SDA inside a data byte
        rb = rx_cnt; sb = stop_cnt;
        bus_start();
        write_byte(8'hC0, a, 0);
        write_byte(8'hA5, a, 1); check_val("gl_ack_a5", a, 1);
        bus_stop();
        wait_clk(4);
        check_val("gl_rx_count", rx_cnt - rb, 1);
        check_val("gl_byte", rx_log[rb], 9'h1A5);
        check_val("gl_stop_pulses", stop_cnt - sb, 1);

        // reset during a data ACK
        rb = rx_cnt; sb = stop_cnt;
        bus_start();
        write_byte(8'hC0, a, 0);
        send_bits(8'h3C, 0);
        sda_low = 1'b0; wait_clk(q);
        scl = 1'b1;     wait_clk(q);
        check_val("rstack_pulled", sda_w, 0);
        check_val("rstack_busy", rx_if.busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check_val("rstack_released", sda_w, 1);
        check_val("rstack_busy_cleared", rx_if.busy, 0);
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(q);
        scl = 1'b0; wait_clk(q);
        bus_stop();
        wait_clk(4);
        check_val("rstack_stop_pulses", stop_cnt - sb, 0);
        check_val("rstack_rx_count", rx_cnt - rb, 1);
        check_val("rstack_byte", rx_log[rb], 9'h13C);

        // next transaction after reset works normally
        rb = rx_cnt;
        bus_start();
        write_byte(8'hC0, a, 0); check_val("post_ack_addr", a, 1);
        write_byte(8'h77, a, 0); check_val("post_ack_77", a, 1);
        bus_stop();
        wait_clk(4);
        check_val("post_byte", rx_log[rb], 9'h177);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter I2C_ADDR, default 7'b1100000, is the 7-bit target address this block acknowledges.
REQ-002 Parameter FILTER_LEN, default 3, is the number of consecutive equal synchronized samples required before an SCL/SDA level change is accepted.
REQ-003 Ports: clk  input  1  system clock; every flop is clocked on the rising edge.
REQ-004 Ports: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Ports: i2c_scl  input  1  bus clock (open-drain, externally pulled up); this block never drives it.
REQ-006 Ports: i2c_sda  inout  1  bus data; driven 0 only when sda_pull is set, otherwise high-Z.
REQ-007 Ports: rx_valid  output  1  received data byte pending.
REQ-008 Ports: rx_data  output  8  received byte, MSB first on the bus.
REQ-009 Ports: rx_first  output  1  qualifies rx_data as the first data byte after an address match.
REQ-010 Ports: rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
REQ-011 Ports: busy  output  1  addressed write transaction in progress.
REQ-012 Ports: stop_pulse  output  1  one-cycle pulse on STOP that ends an addressed transaction.
REQ-013 Ports: overrun  output  1  one-cycle pulse when a byte is NACKed because the previous byte is still pending.

Function
REQ-014 SCL and SDA shall pass through a 2-flop synchronizer, then the FILTER_LEN glitch filter; all decoding uses the filtered levels (scl_f, sda_f).
REQ-015 Timing: clk shall be at least 16x the SCL frequency; the maximum supported SCL is 3.4 MHz.
REQ-016 START: sda_f falls while scl_f is high. STOP: sda_f rises while scl_f is high. Both are detected in any state.
REQ-017 Bit sampling: sda_f is sampled on the scl_f rising edge; a bit counter 0..7 advances on that edge.
REQ-018 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-019 Transition: START (including repeated START) from any state goes to ADDR and clears the bit counter and shift register.
REQ-020 Transition: STOP from any state goes to IDLE; a partially shifted byte is discarded; stop_pulse fires only if busy was 1.
REQ-021 ADDR: after 8 bits, the byte {addr[6:0], rw} is compared. Match with rw=0 goes to ADDR_ACK and sets busy=1 and first_flag=1. A mismatch, or rw=1 (reads unsupported), goes to IGNORE with SDA released.
REQ-022 ADDR_ACK and DATA_ACK pull timing: sda_pull asserts on the scl_f falling edge after the 8th bit and releases on the next scl_f falling edge, at which point the state moves to DATA.
REQ-023 DATA, rx_valid=0: after 8 bits, rx_data <= byte, rx_first <= first_flag, rx_valid <= 1, first_flag <= 0, go to DATA_ACK with ACK.
REQ-024 DATA, rx_valid=1 (still pending): the new byte is dropped, overrun pulses, and DATA_ACK does not pull SDA (NACK). The state then returns to DATA, so the controller may continue or STOP.
REQ-025 Handshake: rx_valid clears the cycle after rx_valid & rx_ready. rx_data and rx_first are stable while rx_valid=1.
REQ-026 Simultaneous accept and new byte completion: the accept is processed first, so the new byte is ACKed and loaded.
REQ-027 A pending byte survives STOP and START; rx_valid stays 1 until it is accepted.
REQ-028 busy clears on STOP, and on a repeated START whose address does not match.
REQ-029 IGNORE: SDA is never driven; the state waits for START or STOP.
REQ-030 Multi-byte writes have no limit on length; the bit counter wraps 7 -> 0 per byte.

Reset
REQ-031 On reset_n=0, asynchronously: state=IDLE, sda_pull=0 (SDA high-Z), rx_valid=0, rx_data=0, rx_first=0, busy=0, stop_pulse=0, overrun=0, and filter outputs=1 (bus idle high).
REQ-032 Reset asserted mid-transaction shall release SDA immediately. After release, the block shall ignore the bus until the next START.

Verification
REQ-033 Write 0xC0, 0x42, 0x0A, 0xBC then STOP at 400 kHz with rx_ready=1 -> ACK on all 4 bytes; 3 bytes delivered as (0x42, first=1), (0x0A, 0), (0xBC, 0); one stop_pulse.
REQ-034 Address 0xC2 (mismatch) then 2 bytes -> SDA never driven low; no rx_valid; no stop_pulse.
REQ-035 Address 0xC1 (read) -> NACK on the address byte, busy stays 0.
REQ-036 rx_ready=0, write 0xC0, 0x11, 0x22 -> 0x11 ACKed and held; 0x22 NACKed; one overrun pulse; rx_data remains 0x11.
REQ-037 Write 0xC0, 0x55, then repeated START, 0xC0, 0x66 -> two bytes, both with rx_first=1; busy stays 1 throughout.
REQ-038 1-clk glitches on SCL and SDA with FILTER_LEN=3 -> no spurious START, STOP or bit; reset_n pulsed during a data byte's ACK -> SDA released in the same cycle.
